// File: rtl/mips_defs.sv
// Shared MIPS encodings for the multi-cycle control unit: opcodes, funcs,
// ALU/NPC/mux selects, FSM states and the decoder's instruction classes.
package mips_defs;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned FN_W  = 6;
  localparam int unsigned SEL_W = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FN_W-1:0] FN_NOP  = 6'h00;
  localparam logic [FN_W-1:0] FN_JR   = 6'h08;
  localparam logic [FN_W-1:0] FN_ADDU = 6'h21;
  localparam logic [FN_W-1:0] FN_SUBU = 6'h23;

  localparam logic [SEL_W-1:0] ALU_ADD = 2'd0;
  localparam logic [SEL_W-1:0] ALU_SUB = 2'd1;
  localparam logic [SEL_W-1:0] ALU_OR  = 2'd2;
  localparam logic [SEL_W-1:0] ALU_LUI = 2'd3;

  localparam logic [SEL_W-1:0] NPC_PC4    = 2'd0;
  localparam logic [SEL_W-1:0] NPC_BRANCH = 2'd1;
  localparam logic [SEL_W-1:0] NPC_JUMP   = 2'd2;
  localparam logic [SEL_W-1:0] NPC_JR     = 2'd3;

  localparam logic [SEL_W-1:0] DST_RT = 2'd0;
  localparam logic [SEL_W-1:0] DST_RD = 2'd1;
  localparam logic [SEL_W-1:0] DST_RA = 2'd2;

  localparam logic [SEL_W-1:0] WD_ALU = 2'd0;
  localparam logic [SEL_W-1:0] WD_DM  = 2'd1;
  localparam logic [SEL_W-1:0] WD_PC4 = 2'd2;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXE,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_WB,
    ST_BRANCH,
    ST_JUMP,
    ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    CL_ALU,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_J,
    CL_JAL,
    CL_JR,
    CL_NOP,
    CL_ILL
  } iclass_e;

  typedef struct packed {
    logic             alu_src;
    logic [SEL_W-1:0] alu_op;
    logic             ext_op;
  } alu_ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational op/func classifier: instruction class, R-type flag and the
// ALU source/operation/extension settings used from EXE onward.
module mc_ctrl_decode
  import mips_defs::*;
(
  input  logic [OP_W-1:0] op_i,
  input  logic [FN_W-1:0] func_i,
  output iclass_e         iclass_o,
  output logic            rtype_o,
  output alu_ctrl_t       alu_o
);

  always_comb begin
    iclass_o = CL_ILL;
    rtype_o  = 1'b0;
    alu_o    = '0;
    case (op_i)
      OP_RTYPE: begin
        rtype_o = 1'b1;
        case (func_i)
          FN_ADDU: begin
            iclass_o      = CL_ALU;
            alu_o.alu_op  = ALU_ADD;
          end
          FN_SUBU: begin
            iclass_o      = CL_ALU;
            alu_o.alu_op  = ALU_SUB;
          end
          FN_JR:   iclass_o = CL_JR;
          FN_NOP:  iclass_o = CL_NOP;
          default: iclass_o = CL_ILL;
        endcase
      end
      OP_ORI: begin
        iclass_o      = CL_ALU;
        alu_o.alu_src = 1'b1;
        alu_o.alu_op  = ALU_OR;
      end
      OP_LUI: begin
        iclass_o      = CL_ALU;
        alu_o.alu_src = 1'b1;
        alu_o.alu_op  = ALU_LUI;
      end
      OP_LW, OP_SW: begin
        iclass_o      = (op_i == OP_LW) ? CL_LW : CL_SW;
        alu_o.alu_src = 1'b1;
        alu_o.alu_op  = ALU_ADD;
        alu_o.ext_op  = 1'b1;
      end
      OP_BEQ:  iclass_o = CL_BEQ;
      OP_J:    iclass_o = CL_J;
      OP_JAL:  iclass_o = CL_JAL;
      default: iclass_o = CL_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// handshakes with variable-latency memory and counts retired instructions.
module mc_ctrl
  import mips_defs::*;
#(
  parameter bit          HALT_ON_ILLEGAL = 1'b1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic [FN_W-1:0]  func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             pc_we,
  output logic             ir_we,
  output logic             reg_we,
  output logic [SEL_W-1:0] reg_dst,
  output logic [SEL_W-1:0] wd_sel,
  output logic             alu_src,
  output logic [SEL_W-1:0] alu_op,
  output logic             ext_op,
  output logic [SEL_W-1:0] npc_sel,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire_c;
  iclass_e          iclass_c;
  logic             rtype_c;
  alu_ctrl_t        alu_c;

  mc_ctrl_decode u_decode (
    .op_i     (op),
    .func_i   (func),
    .iclass_o (iclass_c),
    .rtype_o  (rtype_c),
    .alu_o    (alu_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and retirement; retire_c marks the last cycle of an instruction.
  always_comb begin
    state_d  = state_q;
    retire_c = 1'b0;
    case (state_q)
      ST_FETCH: if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (iclass_c)
          CL_ALU, CL_LW, CL_SW: state_d = ST_EXE;
          CL_BEQ:               state_d = ST_BRANCH;
          CL_J, CL_JAL, CL_JR:  state_d = ST_JUMP;
          CL_NOP: begin
            state_d  = ST_FETCH;
            retire_c = 1'b1;
          end
          default: begin
            if (HALT_ON_ILLEGAL) begin
              state_d = ST_HALT;
            end else begin
              state_d  = ST_FETCH;
              retire_c = 1'b1;
            end
          end
        endcase
      end
      ST_EXE: begin
        case (iclass_c)
          CL_LW:   state_d = ST_MEM_RD;
          CL_SW:   state_d = ST_MEM_WR;
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM_RD: if (mem_ready) state_d = ST_WB;
      ST_MEM_WR: begin
        if (mem_ready) begin
          state_d  = ST_FETCH;
          retire_c = 1'b1;
        end
      end
      ST_WB, ST_BRANCH, ST_JUMP: begin
        state_d  = ST_FETCH;
        retire_c = 1'b1;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
    retired_d = retire_c ? retired_q + CNT_W'(1) : retired_q;
  end

  // Control outputs follow the current state; everything is forced low in reset.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    ir_we    = 1'b0;
    reg_we   = 1'b0;
    reg_dst  = DST_RT;
    wd_sel   = WD_ALU;
    alu_src  = 1'b0;
    alu_op   = ALU_ADD;
    ext_op   = 1'b0;
    npc_sel  = NPC_PC4;
    halted   = 1'b0;
    if (reset) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            npc_sel = NPC_PC4;
          end
        end
        ST_EXE: begin
          alu_src = alu_c.alu_src;
          alu_op  = alu_c.alu_op;
          ext_op  = alu_c.ext_op;
        end
        ST_MEM_RD, ST_MEM_WR: begin
          dmem_req = 1'b1;
          dmem_we  = (state_q == ST_MEM_WR);
          alu_src  = alu_c.alu_src;
          alu_op   = alu_c.alu_op;
          ext_op   = alu_c.ext_op;
        end
        ST_WB: begin
          reg_we  = 1'b1;
          reg_dst = rtype_c ? DST_RD : DST_RT;
          wd_sel  = (iclass_c == CL_LW) ? WD_DM : WD_ALU;
          alu_src = alu_c.alu_src;
          alu_op  = alu_c.alu_op;
          ext_op  = alu_c.ext_op;
        end
        ST_BRANCH: begin
          alu_op  = ALU_SUB;
          ext_op  = 1'b1;
          pc_we   = zero;
          npc_sel = NPC_BRANCH;
        end
        ST_JUMP: begin
          pc_we   = 1'b1;
          npc_sel = (iclass_c == CL_JR) ? NPC_JR : NPC_JUMP;
          if (iclass_c == CL_JAL) begin
            reg_we  = 1'b1;
            reg_dst = DST_RA;
            wd_sel  = WD_PC4;
          end
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign retired = retired_q;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit. It sequences the shared datapath (PC, IR, GRF, ALU, DM) through fetch, decode, execute, memory and writeback states.
- Consumes op/func from the instruction field splitter and the ALU zero flag. Drives all datapath enables and muxes.
- Handshakes with a variable-latency memory via req/ready. Counts retired instructions.

Parameters:
- HALT_ON_ILLEGAL, 1, 1: an unsupported opcode/func enters HALT. 0: it is treated as nop.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- op  input  6  instr[31:26] from the IR field splitter
- func  input  6  instr[5:0]
- zero  input  1  ALU result == 0
- mem_ready  input  1  memory completes the current request this cycle
- imem_req  output  1  instruction fetch request
- dmem_req  output  1  data access request
- dmem_we  output  1  data access is a store
- pc_we  output  1  PC load enable
- ir_we  output  1  IR load enable
- reg_we  output  1  GRF write enable
- reg_dst  output  2  0=rt, 1=rd, 2=$31
- wd_sel  output  2  0=ALU, 1=DM, 2=PC+4
- alu_src  output  1  0=rt, 1=extended imm
- alu_op  output  2  0=ADD, 1=SUB, 2=OR, 3=LUI
- ext_op  output  1  0=zero-extend, 1=sign-extend
- npc_sel  output  2  0=PC+4, 1=branch, 2=j/jal, 3=jr
- halted  output  1  HALT state
- retired  output  CNT_W  retired-instruction count

Behaviour:
- Supported instructions:
  - op 0x00 with func 0x21 addu, 0x23 subu, 0x08 jr, 0x00 nop/sll-0.
  - op 0x0D ori, 0x23 lw, 0x2B sw, 0x04 beq, 0x0F lui, 0x02 j, 0x03 jal.
- Reset: state=FETCH, retired=0. Every output is 0 while reset is low. On release, the first edge evaluates FETCH.
- Outputs are Moore, decoded from state plus op/func. op/func are valid from DECODE onward, because the IR is loaded at the end of FETCH.
- FETCH:
  - imem_req=1.
  - When mem_ready=1: ir_we=1, pc_we=1, npc_sel=0, next state DECODE.
  - When mem_ready=0: hold; no enables asserted.
- DECODE (1 cycle):
  - addu/subu/ori/lui/lw/sw go to EXE.
  - beq goes to BRANCH.
  - j/jal/jr go to JUMP.
  - nop goes to FETCH and increments retired.
  - Illegal goes to HALT if HALT_ON_ILLEGAL, else to FETCH with retired incremented.
- EXE (1 cycle): sets alu_src, alu_op, ext_op.
  - lw goes to MEM_RD, sw goes to MEM_WR, all others go to WB.
  - ALU settings: addu ADD/rt; subu SUB/rt; ori OR/imm/zext; lui LUI/imm; lw/sw ADD/imm/sext.
- MEM_RD:
  - dmem_req=1, dmem_we=0, ALU controls held.
  - Goes to WB when mem_ready=1, else waits.
- MEM_WR:
  - dmem_req=1, dmem_we=1.
  - When mem_ready=1: goes to FETCH and increments retired.
- WB (1 cycle):
  - reg_we=1. reg_dst: rd for R-type, rt otherwise. wd_sel: DM for lw, ALU otherwise.
  - Goes to FETCH and increments retired.
- BRANCH (1 cycle): alu_op=SUB, alu_src=0, ext_op=1. pc_we=zero, npc_sel=1. Goes to FETCH and increments retired.
- JUMP (1 cycle):
  - pc_we=1. npc_sel=2 for j/jal, 3 for jr.
  - jal additionally asserts reg_we=1, reg_dst=2, wd_sel=2.
  - Goes to FETCH and increments retired.
- HALT: absorbing; all enables 0, halted=1. Only reset exits it.
- Cycle counts with zero-wait memory:
  - R/ori/lui: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/j/jal/jr: 3 cycles.
  - nop: 2 cycles.
- Memory handshake:
  - A req stays high until the cycle mem_ready=1 is sampled.
  - mem_ready while no req is outstanding is ignored.
- retired: increments exactly once per completed instruction and wraps modulo 2^CNT_W.
- Reset mid-instruction (e.g. in MEM_RD): immediate return to FETCH with all outputs 0. No partial writeback survives.

Decomposition:
- Shared package mips_defs holds:
  - Opcode/func constants (OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_J, OP_JAL; FN_ADDU, FN_SUBU, FN_JR).
  - ALU_* and NPC_* encodings.
  - The state enum.
- One natural sub-module, mc_ctrl_decode: a combinational class decoder from op/func to instruction class and ALU/ext settings. The FSM and counter stay in mc_ctrl.

Test Plan:
- Reset low for 3 cycles, release, mem_ready tied 1 -> imem_req=1 in the first cycle; ir_we=pc_we=1 that cycle; all other outputs 0; retired=0.
- addu (op 0, func 0x21), zero-wait -> 4 cycles; WB has reg_we=1, reg_dst=1, wd_sel=0, alu_op=0; retired=1.
- lw (op 0x23) with mem_ready low 3 cycles in MEM_RD -> dmem_req held 4 cycles, dmem_we=0; then WB with wd_sel=1, reg_dst=0; 8 cycles total.
- beq with zero=0, then beq with zero=1 -> pc_we=0 then pc_we=1 in BRANCH, npc_sel=1 both times; retired increments by 2.
- jal (op 0x03) -> JUMP has pc_we=1, npc_sel=2, reg_we=1, reg_dst=2, wd_sel=2. jr (func 0x08) -> npc_sel=3, reg_we=0.
- op 0x3F with HALT_ON_ILLEGAL=1 -> halted=1 from the cycle after DECODE and all enables 0 for 20 cycles. Reset low pulse during HALT -> FETCH.
